// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and data OBI ports.
// Data has priority, fetch has a starvation guard, and an in-order FIFO routes responses back.
module mem_port_arbiter #(
  parameter int unsigned MEM_W           = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 imem_req_i,
  output logic                                 imem_gnt_o,
  input  logic [31:0]                          imem_addr_i,
  output logic                                 imem_rvalid_o,
  output logic                                 imem_err_o,
  output logic [31:0]                          imem_rdata_o,
  input  logic                                 dmem_req_i,
  output logic                                 dmem_gnt_o,
  input  logic [31:0]                          dmem_addr_i,
  input  logic                                 dmem_we_i,
  input  logic [MEM_W/8-1:0]                   dmem_be_i,
  input  logic [MEM_W-1:0]                     dmem_wdata_i,
  output logic                                 dmem_rvalid_o,
  output logic                                 dmem_err_o,
  output logic [MEM_W-1:0]                     dmem_rdata_o,
  output logic                                 mem_req_o,
  input  logic                                 mem_gnt_i,
  output logic [31:0]                          mem_addr_o,
  output logic                                 mem_we_o,
  output logic [MEM_W/8-1:0]                   mem_be_o,
  output logic [MEM_W-1:0]                     mem_wdata_o,
  input  logic                                 mem_rvalid_i,
  input  logic                                 mem_err_i,
  input  logic [MEM_W-1:0]                     mem_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 protocol_err_o
);

  localparam int unsigned PtrW  = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CntW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned Words = MEM_W / 32;
  localparam int unsigned LaneW = (Words > 1) ? $clog2(Words) : 1;
  localparam logic [7:0]  StarveMax = 8'(STARVE_LIMIT);

  logic            can_issue, sel_fetch, push, pop;
  logic [LaneW-1:0] push_lane, head_lane;
  logic            head_src;

  logic [CntW-1:0] count_q, count_d;
  logic [7:0]      starve_q, starve_d;
  logic            err_q, err_d;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [MAX_OUTSTANDING-1:0] src_q;
  logic [LaneW-1:0] lane_q [MAX_OUTSTANDING];

  assign can_issue = (count_q < CntW'(MAX_OUTSTANDING));
  assign sel_fetch = imem_req_i & (~dmem_req_i | (starve_q == StarveMax));
  assign mem_req_o = can_issue & (imem_req_i | dmem_req_i);
  assign imem_gnt_o = can_issue & sel_fetch & mem_gnt_i;
  assign dmem_gnt_o = can_issue & ~sel_fetch & dmem_req_i & mem_gnt_i;
  assign push      = mem_req_o & mem_gnt_i;
  assign pop       = mem_rvalid_i & (count_q != '0);
  // Word lane within the memory beat; the mask is zero on 32-bit memories.
  assign push_lane = LaneW'((mem_addr_o >> 2) & 32'(Words - 1));
  assign head_src  = src_q[rd_ptr_q];
  assign head_lane = lane_q[rd_ptr_q];

  always_comb begin
    mem_addr_o  = dmem_addr_i;
    mem_we_o    = dmem_we_i;
    mem_be_o    = dmem_be_i;
    mem_wdata_o = dmem_wdata_i;
    if (sel_fetch) begin
      mem_addr_o  = imem_addr_i;
      mem_we_o    = 1'b0;
      mem_be_o    = '1;
      mem_wdata_o = '0;
    end
  end

  always_comb begin
    imem_rdata_o = mem_rdata_i[31:0];
    for (int w = 0; w < Words; w++) begin
      if (LaneW'(w) == head_lane) imem_rdata_o = mem_rdata_i[w*32 +: 32];
    end
  end

  assign dmem_rdata_o  = mem_rdata_i;
  assign imem_rvalid_o = pop & ~head_src;
  assign dmem_rvalid_o = pop & head_src;
  assign imem_err_o    = pop & ~head_src & mem_err_i;
  assign dmem_err_o    = pop & head_src & mem_err_i;

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + CntW'(1);
    else if (!push && pop) count_d = count_q - CntW'(1);
    err_d = err_q | (mem_rvalid_i & (count_q == '0));
    starve_d = starve_q;
    if (!imem_req_i || imem_gnt_o) starve_d = '0;
    else if (can_issue && starve_q != StarveMax) starve_d = starve_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      src_q    <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) lane_q[i] <= '0;
    end else begin
      count_q  <= count_d;
      starve_q <= starve_d;
      err_q    <= err_d;
      if (push) begin
        src_q[wr_ptr_q]  <= ~sel_fetch;
        lane_q[wr_ptr_q] <= push_lane;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  assign outstanding_o  = count_q;
  assign protocol_err_o = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at MEM_W=64, MAX_OUTSTANDING=4, STARVE_LIMIT=3.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_mem_port_arbiter;
  localparam int unsigned MemW = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic imem_req, imem_gnt, imem_rvalid, imem_err;
  logic [31:0] imem_addr, imem_rdata;
  logic dmem_req, dmem_gnt, dmem_we, dmem_rvalid, dmem_err;
  logic [31:0] dmem_addr;
  logic [MemW/8-1:0] dmem_be, mem_be;
  logic [MemW-1:0] dmem_wdata, dmem_rdata, mem_wdata, mem_rdata;
  logic mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;
  logic [31:0] mem_addr;
  logic [2:0] outstanding;
  logic protocol_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_W(MemW), .MAX_OUTSTANDING(4), .STARVE_LIMIT(3)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_i(imem_req), .imem_gnt_o(imem_gnt), .imem_addr_i(imem_addr),
    .imem_rvalid_o(imem_rvalid), .imem_err_o(imem_err), .imem_rdata_o(imem_rdata),
    .dmem_req_i(dmem_req), .dmem_gnt_o(dmem_gnt), .dmem_addr_i(dmem_addr),
    .dmem_we_i(dmem_we), .dmem_be_i(dmem_be), .dmem_wdata_i(dmem_wdata),
    .dmem_rvalid_o(dmem_rvalid), .dmem_err_o(dmem_err), .dmem_rdata_o(dmem_rdata),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid),
    .mem_err_i(mem_err), .mem_rdata_i(mem_rdata),
    .outstanding_o(outstanding), .protocol_err_o(protocol_err)
  );

  task automatic idle_inputs();
    imem_req = 0; imem_addr = '0; dmem_req = 0; dmem_addr = '0; dmem_we = 0;
    dmem_be = '0; dmem_wdata = '0; mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
    mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    #1;
    checks++;
    if (outstanding !== 3'd0) begin
      errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding);
    end
    checks++;
    if ({protocol_err, mem_req, imem_gnt, dmem_gnt, imem_rvalid, dmem_rvalid} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 000000",
        {protocol_err, mem_req, imem_gnt, dmem_gnt, imem_rvalid, dmem_rvalid});
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_fetch_lane();
    @(negedge clk);
    imem_req = 1; imem_addr = 32'h84; mem_gnt = 1;
    #1;
    checks++;
    if ({mem_req, imem_gnt, dmem_gnt, mem_we} !== 4'b1100 || mem_addr !== 32'h84
        || mem_be !== 8'hFF || mem_wdata !== '0) begin
      errors++; $display("FAIL fetch_request: req/gnt/dgnt/we=%b addr=%h be=%h want 1100 84 ff",
        {mem_req, imem_gnt, dmem_gnt, mem_we}, mem_addr, mem_be);
    end
    @(negedge clk);
    imem_req = 0; mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 64'h11112222_33334444;
    #1;
    checks++;
    if (outstanding !== 3'd1) begin
      errors++; $display("FAIL fetch_outstanding_1: got %0d want 1", outstanding);
    end
    checks++;
    if (imem_rvalid !== 1'b1 || dmem_rvalid !== 1'b0 || imem_rdata !== 32'h11112222) begin
      errors++; $display("FAIL fetch_lane_rdata: rv=%b drv=%b data=%h want 1 0 11112222",
        imem_rvalid, dmem_rvalid, imem_rdata);
    end
    @(negedge clk);
    mem_rvalid = 0;
    #1;
    checks++;
    if (outstanding !== 3'd0) begin
      errors++; $display("FAIL fetch_outstanding_0: got %0d want 0", outstanding);
    end
  endtask

  task automatic test_starvation();
    logic [4:0] exp_fetch_gnt;
    logic [4:0] exp_fetch_rsp;
    exp_fetch_gnt = 5'b01000;
    exp_fetch_rsp = 5'b10000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      imem_req = 1; imem_addr = 32'h200; dmem_req = 1; dmem_addr = 32'h300;
      mem_gnt = 1; mem_rvalid = (i > 0);
      #1;
      checks++;
      if (imem_gnt !== exp_fetch_gnt[i] || dmem_gnt !== !exp_fetch_gnt[i]) begin
        errors++; $display("FAIL starve_grant_cycle%0d: igate=%b dgnt=%b want igate=%b",
          i, imem_gnt, dmem_gnt, exp_fetch_gnt[i]);
      end
      if (i > 0) begin
        checks++;
        if (imem_rvalid !== exp_fetch_rsp[i] || dmem_rvalid !== !exp_fetch_rsp[i]) begin
          errors++; $display("FAIL starve_route_cycle%0d: irv=%b drv=%b want irv=%b",
            i, imem_rvalid, dmem_rvalid, exp_fetch_rsp[i]);
        end
      end
    end
    @(negedge clk);
    imem_req = 0; dmem_req = 0; mem_gnt = 0; mem_rvalid = 1;
    #1;
    checks++;
    if (outstanding !== 3'd1 || dmem_rvalid !== 1'b1) begin
      errors++; $display("FAIL starve_drain: outstanding=%0d drv=%b want 1 1",
        outstanding, dmem_rvalid);
    end
    @(negedge clk);
    mem_rvalid = 0;
  endtask

  task automatic test_full();
    @(negedge clk);
    dmem_req = 1; dmem_addr = 32'h100; mem_gnt = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (outstanding !== 3'd4 || mem_req !== 1'b0 || dmem_gnt !== 1'b0) begin
      errors++; $display("FAIL full_block: outstanding=%0d req=%b gnt=%b want 4 0 0",
        outstanding, mem_req, dmem_gnt);
    end
    mem_rvalid = 1;
    #1;
    checks++;
    if (dmem_rvalid !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL full_no_lookahead: drv=%b req=%b want 1 0", dmem_rvalid, mem_req);
    end
    @(negedge clk);
    mem_rvalid = 0;
    #1;
    checks++;
    if (outstanding !== 3'd3 || mem_req !== 1'b1 || dmem_gnt !== 1'b1) begin
      errors++; $display("FAIL full_reopen: outstanding=%0d req=%b gnt=%b want 3 1 1",
        outstanding, mem_req, dmem_gnt);
    end
    @(negedge clk);
    dmem_req = 0; mem_gnt = 0; mem_rvalid = 1;
    repeat (4) @(negedge clk);
    mem_rvalid = 0;
    #1;
    checks++;
    if (outstanding !== 3'd0) begin
      errors++; $display("FAIL full_drain: got %0d want 0", outstanding);
    end
  endtask

  task automatic test_interleave();
    @(negedge clk);
    imem_req = 1; imem_addr = 32'h0; mem_gnt = 1;
    @(negedge clk);
    imem_req = 0; dmem_req = 1; dmem_addr = 32'h40; dmem_we = 1; dmem_be = 8'h0F;
    dmem_wdata = 64'hDEAD;
    #1;
    checks++;
    if (mem_we !== 1'b1 || mem_be !== 8'h0F || mem_wdata !== 64'hDEAD || mem_addr !== 32'h40) begin
      errors++; $display("FAIL inter_data_fields: we=%b be=%h wdata=%h addr=%h want 1 0f dead 40",
        mem_we, mem_be, mem_wdata, mem_addr);
    end
    @(negedge clk);
    dmem_req = 0; dmem_we = 0; dmem_be = '0; imem_req = 1; imem_addr = 32'h8;
    @(negedge clk);
    imem_req = 0; mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 64'hA;
    #1;
    checks++;
    if (outstanding !== 3'd3 || imem_rvalid !== 1'b1 || dmem_rvalid !== 1'b0
        || imem_rdata !== 32'hA) begin
      errors++; $display("FAIL inter_rsp_a: out=%0d irv=%b drv=%b data=%h want 3 1 0 a",
        outstanding, imem_rvalid, dmem_rvalid, imem_rdata);
    end
    @(negedge clk);
    mem_rdata = 64'hB; mem_err = 1;
    #1;
    checks++;
    if (dmem_rvalid !== 1'b1 || imem_rvalid !== 1'b0 || dmem_rdata !== 64'hB
        || dmem_err !== 1'b1 || imem_err !== 1'b0) begin
      errors++; $display("FAIL inter_rsp_b: drv=%b irv=%b data=%h derr=%b ierr=%b want 1 0 b 1 0",
        dmem_rvalid, imem_rvalid, dmem_rdata, dmem_err, imem_err);
    end
    @(negedge clk);
    mem_rdata = 64'hC; mem_err = 0;
    #1;
    checks++;
    if (imem_rvalid !== 1'b1 || dmem_rvalid !== 1'b0 || imem_rdata !== 32'hC) begin
      errors++; $display("FAIL inter_rsp_c: irv=%b drv=%b data=%h want 1 0 c",
        imem_rvalid, dmem_rvalid, imem_rdata);
    end
    @(negedge clk);
    mem_rvalid = 0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    dmem_req = 1; dmem_addr = 32'h0; mem_gnt = 1;
    @(negedge clk);
    dmem_req = 0; imem_req = 1; imem_addr = 32'h4;
    @(negedge clk);
    imem_req = 0; dmem_req = 1; dmem_addr = 32'h10;
    mem_rvalid = 1; mem_rdata = 64'h55;
    #1;
    checks++;
    if (dmem_gnt !== 1'b1 || dmem_rvalid !== 1'b1 || imem_rvalid !== 1'b0
        || dmem_rdata !== 64'h55) begin
      errors++; $display("FAIL b2b_push_pop: gnt=%b drv=%b irv=%b data=%h want 1 1 0 55",
        dmem_gnt, dmem_rvalid, imem_rvalid, dmem_rdata);
    end
    @(negedge clk);
    dmem_req = 0; mem_gnt = 0; mem_rdata = 64'h77777777_66666666;
    #1;
    checks++;
    if (outstanding !== 3'd2 || imem_rvalid !== 1'b1 || imem_rdata !== 32'h77777777) begin
      errors++; $display("FAIL b2b_count_fetch: out=%0d irv=%b data=%h want 2 1 77777777",
        outstanding, imem_rvalid, imem_rdata);
    end
    @(negedge clk);
    mem_rdata = 64'h99;
    #1;
    checks++;
    if (dmem_rvalid !== 1'b1 || dmem_rdata !== 64'h99) begin
      errors++; $display("FAIL b2b_last: drv=%b data=%h want 1 99", dmem_rvalid, dmem_rdata);
    end
    @(negedge clk);
    mem_rvalid = 0;
  endtask

  task automatic test_protocol_err();
    @(negedge clk);
    mem_rvalid = 1;
    #1;
    checks++;
    if (imem_rvalid !== 1'b0 || dmem_rvalid !== 1'b0 || protocol_err !== 1'b0) begin
      errors++; $display("FAIL perr_empty_rsp: irv=%b drv=%b perr=%b want 0 0 0",
        imem_rvalid, dmem_rvalid, protocol_err);
    end
    @(negedge clk);
    mem_rvalid = 0;
    #1;
    checks++;
    if (protocol_err !== 1'b1 || outstanding !== 3'd0) begin
      errors++; $display("FAIL perr_set: perr=%b out=%0d want 1 0", protocol_err, outstanding);
    end
    rst_n = 0;
    #1;
    checks++;
    if (protocol_err !== 1'b0) begin
      errors++; $display("FAIL perr_clear: got %b want 0", protocol_err);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    dmem_req = 1; dmem_addr = 32'h20; mem_gnt = 1;
    @(negedge clk); @(negedge clk);
    dmem_req = 0; mem_gnt = 0;
    #1;
    checks++;
    if (outstanding !== 3'd2) begin
      errors++; $display("FAIL perr_inflight: got %0d want 2", outstanding);
    end
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    mem_rvalid = 1;
    #1;
    checks++;
    if (outstanding !== 3'd0 || imem_rvalid !== 1'b0 || dmem_rvalid !== 1'b0) begin
      errors++; $display("FAIL perr_stale_rsp: out=%0d irv=%b drv=%b want 0 0 0",
        outstanding, imem_rvalid, dmem_rvalid);
    end
    @(negedge clk);
    mem_rvalid = 0;
    #1;
    checks++;
    if (protocol_err !== 1'b1) begin
      errors++; $display("FAIL perr_stale_set: got %b want 1", protocol_err);
    end
    rst_n = 0;
    #1;
    checks++;
    if (protocol_err !== 1'b0) begin
      errors++; $display("FAIL perr_final_clear: got %b want 0", protocol_err);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_fetch_lane();
    test_starvation();
    test_full();
    test_interleave();
    test_back_to_back();
    test_protocol_err();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
